// File: rtl/bz_music_player.sv
// Buzzer music sequencer: walks a per-song note list in an external synchronous ROM and
// plays each note as a square wave, with rests, an inter-note gap, loop, pause and stop.
module bz_music_player #(
    parameter int SEL_W     = 2,
    parameter int ADDR_W    = 8,
    parameter int DIV_W     = 20,
    parameter int BEAT_W    = 4,
    parameter int BEAT_UNIT = 3_125_000,
    parameter int GAP_CYC   = 250_000,
    parameter int CNT_W     = 28
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      loop_en,
    input  logic [SEL_W-1:0]          song_sel,
    output logic [SEL_W+ADDR_W-1:0]   rom_addr,
    input  logic [DIV_W+BEAT_W-1:0]   rom_data,
    output logic                      beep,
    output logic                      busy,
    output logic                      music_interrupt,
    output logic [DIV_W-1:0]          cur_div
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0]  UNIT    = CNT_W'(BEAT_UNIT);
    localparam logic [CNT_W-1:0]  GAP     = CNT_W'(GAP_CYC);
    localparam logic [ADDR_W-1:0] IDX_MAX = '1;

    state_t                    state_q, state_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic [SEL_W+ADDR_W-1:0]   addr_q, addr_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [CNT_W-1:0]          dur_q, dur_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIV_W-1:0]          tone_q, tone_d;
    logic                      beep_q, beep_d;
    logic                      busy_q, busy_d;

    logic [DIV_W-1:0]          rom_half;
    logic [BEAT_W-1:0]         rom_beat;
    logic [CNT_W-1:0]          dur_calc;
    logic [ADDR_W-1:0]         idx_inc;
    logic                      note_done;
    logic                      song_end;
    logic                      active;

    assign rom_half = rom_data[DIV_W+BEAT_W-1:BEAT_W];
    assign rom_beat = rom_data[BEAT_W-1:0];
    // The gap is carved out of the note's nominal length so the beat grid stays intact.
    assign dur_calc = CNT_W'(rom_beat) * UNIT - GAP;
    assign idx_inc  = idx_q + 1'b1;
    assign active   = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                      (state_q == S_PLAY)  || (state_q == S_GAP);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        div_d     = div_q;
        dur_d     = dur_q;
        cnt_d     = cnt_q;
        tone_d    = tone_q;
        beep_d    = beep_q;
        busy_d    = busy_q;
        note_done = 1'b0;
        song_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    sel_d   = song_sel;
                    idx_d   = '0;
                    addr_d  = {song_sel, {ADDR_W{1'b0}}};
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rom_beat == '0) begin
                    song_end = 1'b1;
                end else begin
                    div_d   = rom_half;
                    dur_d   = dur_calc;
                    cnt_d   = '0;
                    tone_d  = '0;
                    beep_d  = 1'b0;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q != '0) begin
                    if (tone_q == div_q - 1'b1) begin
                        tone_d = '0;
                        beep_d = ~beep_q;
                    end else begin
                        tone_d = tone_q + 1'b1;
                    end
                end
                if (cnt_q == dur_q - 1'b1) begin
                    cnt_d  = '0;
                    tone_d = '0;
                    beep_d = 1'b0;
                    if (GAP_CYC == 0) note_done = 1'b1;
                    else              state_d   = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == GAP - 1'b1) note_done = 1'b1;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The last slot of a song acts as an implicit end marker.
        if (note_done) begin
            if (idx_q == IDX_MAX) begin
                song_end = 1'b1;
            end else begin
                idx_d   = idx_inc;
                addr_d  = {sel_q, idx_inc};
                cnt_d   = '0;
                state_d = S_FETCH;
            end
        end

        if (song_end) begin
            if (loop_en) begin
                idx_d   = '0;
                addr_d  = {sel_q, {ADDR_W{1'b0}}};
                cnt_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_DONE;
            end
        end

        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            beep_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
            tone_d  = '0;
        end else if (pause && active) begin
            // Hold everything, including the tone phase, so the note resumes seamlessly.
            state_d = state_q;
            idx_d   = idx_q;
            addr_d  = addr_q;
            div_d   = div_q;
            dur_d   = dur_q;
            cnt_d   = cnt_q;
            tone_d  = tone_q;
            beep_d  = beep_q;
            busy_d  = busy_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            div_q   <= '0;
            dur_q   <= '0;
            cnt_q   <= '0;
            tone_q  <= '0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            div_q   <= div_d;
            dur_q   <= dur_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
            beep_q  <= beep_d;
            busy_q  <= busy_d;
        end
    end

    assign rom_addr        = addr_q;
    assign busy            = busy_q;
    assign beep            = beep_q & ~pause;
    assign music_interrupt = (state_q == S_DONE) && !stop;
    assign cur_div         = (state_q == S_PLAY) ? div_q : '0;

endmodule

// File: tb/tb_bz_music_player.sv
// Scoreboard bench for bz_music_player: stimulus queues expected output events, a negedge
// monitor detects address/divider changes, beep rises, interrupts and busy falls and compares.
module tb_bz_music_player;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [1:0]  song_sel = '0;
    logic [3:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic        beep, busy, music_interrupt;
    logic [7:0]  cur_div;

    bz_music_player #(
        .SEL_W(2), .ADDR_W(2), .DIV_W(8), .BEAT_W(4),
        .BEAT_UNIT(100), .GAP_CYC(10), .CNT_W(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .song_sel(song_sel), .rom_addr(rom_addr),
        .rom_data(rom_data), .beep(beep), .busy(busy),
        .music_interrupt(music_interrupt), .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    logic [11:0] rom_mem [16];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int val; int off; } ev_t;
    ev_t exp_q[$];
    int  t0 = 0;
    int  vecs = 0, errs = 0;
    bit  mon_en = 1'b0;

    localparam int EV_ADDR = 0, EV_DIV = 1, EV_RISE = 2, EV_IRQ = 3, EV_BUSY0 = 4;

    task automatic push(input int kind, input int val, input int off);
        ev_t e;
        e.kind = kind; e.val = val; e.off = off;
        exp_q.push_back(e);
    endtask

    // Expected events for one note whose PLAY phase starts at offset ps.
    task automatic note(input int ps, input int d, input int beat);
        int dur;
        dur = beat * 100 - 10;
        if (d != 0) begin
            push(EV_DIV, d, ps);
            for (int k = 0; d + 2 * d * k < dur; k++) push(EV_RISE, d, ps + d + 2 * d * k);
            push(EV_DIV, 0, ps + dur);
        end
    endtask

    task automatic cmp(input string name, input int act, input int expv);
        vecs++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic observe(input int kind, input int val, input int off);
        ev_t e;
        vecs++;
        if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_event: got kind %0d val %0d at +%0d, expected none", kind, val, off);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.off != off) begin
                errs++;
                $display("FAIL event: got kind %0d val %0d at +%0d, expected kind %0d val %0d at +%0d",
                         kind, val, off, e.kind, e.val, e.off);
            end
        end
    endtask

    logic [3:0] p_addr = '0;
    logic [7:0] p_div  = '0;
    logic       p_beep = 1'b0, p_busy = 1'b0;

    always @(negedge clk) begin
        int off;
        off = cyc - t0;
        if (mon_en) begin
            if (rom_addr != p_addr)    observe(EV_ADDR, int'(rom_addr), off);
            if (cur_div != p_div)      observe(EV_DIV, int'(cur_div), off);
            if (beep && !p_beep)       observe(EV_RISE, int'(cur_div), off);
            if (music_interrupt)       observe(EV_IRQ, 0, off);
            if (!busy && p_busy)       observe(EV_BUSY0, 0, off);
        end
        p_addr = rom_addr;
        p_div  = cur_div;
        p_beep = beep;
        p_busy = busy;
    end

    task automatic go(input logic [1:0] s);
        @(posedge clk); #1;
        t0 = cyc;
        song_sel = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_to(input int off);
        while (cyc - t0 < off) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drained(input string name);
        cmp(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = '0;
        rom_mem[0]  = {8'd3, 4'd1};
        rom_mem[1]  = {8'd0, 4'd1};
        rom_mem[2]  = {8'd2, 4'd1};
        rom_mem[3]  = {8'd4, 4'd1};
        rom_mem[4]  = {8'd5, 4'd2};
        rom_mem[8]  = {8'd2, 4'd1};
        rom_mem[12] = {8'd3, 4'd3};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        cmp("por_beep", beep, 0);
        cmp("por_busy", busy, 0);
        cmp("por_irq", music_interrupt, 0);
        cmp("por_addr", rom_addr, 0);
        cmp("por_cur_div", cur_div, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Song 1: one note then end marker
        push(EV_ADDR, 4, 1);
        note(3, 5, 2);
        push(EV_ADDR, 5, 203);
        push(EV_IRQ, 0, 205);
        push(EV_BUSY0, 0, 206);
        go(2'd1);
        wait_to(215);
        drained("song1_drain");

        // Song 0: four notes incl. a rest, no marker; stray start mid-song
        push(EV_ADDR, 0, 1);
        note(3, 3, 1);
        push(EV_ADDR, 1, 103);
        note(105, 0, 1);
        push(EV_ADDR, 2, 205);
        note(207, 2, 1);
        push(EV_ADDR, 3, 307);
        note(309, 4, 1);
        push(EV_IRQ, 0, 409);
        push(EV_BUSY0, 0, 410);
        go(2'd0);
        wait_to(50);
        start = 1'b1;
        song_sel = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_to(420);
        drained("song0_drain");

        // Song 2 with loop: two passes, loop dropped during the second
        for (int b = 0; b <= 104; b += 104) begin
            push(EV_ADDR, 8, b + 1);
            note(b + 3, 2, 1);
            push(EV_ADDR, 9, b + 103);
        end
        push(EV_IRQ, 0, 209);
        push(EV_BUSY0, 0, 210);
        loop_en = 1'b1;
        go(2'd2);
        wait_to(150);
        loop_en = 1'b0;
        wait_to(220);
        drained("loop_drain");

        // Song 3 with 50-cycle pause starting in a beep-high phase
        push(EV_ADDR, 12, 1);
        push(EV_DIV, 3, 3);
        for (int k = 0; k < 5; k++) push(EV_RISE, 3, 6 + 6 * k);
        push(EV_RISE, 3, 81);
        for (int k = 0; k < 43; k++) push(EV_RISE, 3, 86 + 6 * k);
        push(EV_DIV, 0, 343);
        push(EV_ADDR, 13, 353);
        push(EV_IRQ, 0, 355);
        push(EV_BUSY0, 0, 356);
        go(2'd3);
        wait_to(31);
        pause = 1'b1;
        wait_to(81);
        pause = 1'b0;
        wait_to(366);
        drained("pause_drain");

        // Stop mid-note: immediate silence, no interrupt
        push(EV_ADDR, 12, 1);
        push(EV_DIV, 3, 3);
        push(EV_RISE, 3, 6);
        push(EV_RISE, 3, 12);
        push(EV_RISE, 3, 18);
        push(EV_DIV, 0, 21);
        push(EV_BUSY0, 0, 21);
        go(2'd3);
        wait_to(20);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        cmp("stop_beep", beep, 0);
        cmp("stop_busy", busy, 0);
        wait_to(300);
        drained("stop_drain");

        // start and stop together in IDLE
        @(posedge clk); #1;
        song_sel = 2'd1;
        start = 1'b1;
        stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("startstop_busy", busy, 0);
        cmp("startstop_addr", rom_addr, 12);

        // Reset mid-note
        mon_en = 1'b0;
        go(2'd1);
        wait_to(50);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmp("rst_beep", beep, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_irq", music_interrupt, 0);
        cmp("rst_addr", rom_addr, 0);
        cmp("rst_cur_div", cur_div, 0);
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        t0 = cyc;
        wait_to(300);
        drained("rst_quiet");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
